// File: rtl/display_timings.sv
// Display timing generator on the pixel clock: waits for a synchronised MMCM lock,
// lets the clock settle, then produces syncs, data enable, strobes and coordinates.
module display_timings #(
    parameter int   H_RES     = 1280,
    parameter int   H_FP      = 110,
    parameter int   H_SYNC    = 40,
    parameter int   H_BP      = 220,
    parameter int   V_RES     = 720,
    parameter int   V_FP      = 5,
    parameter int   V_SYNC    = 5,
    parameter int   V_BP      = 20,
    parameter logic H_POL     = 1'b1,
    parameter logic V_POL     = 1'b1,
    parameter int   LOCK_WAIT = 1024,
    parameter int   CORDW     = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_locked,
    output logic             o_hs,
    output logic             o_vs,
    output logic             o_de,
    output logic             o_frame,
    output logic             o_line,
    output logic [CORDW-1:0] o_sx,
    output logic [CORDW-1:0] o_sy,
    output logic             o_running
);

    localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;
    localparam int SW      = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;

    localparam logic [CORDW-1:0] H_MAX  = CORDW'(H_TOTAL - 1);
    localparam logic [CORDW-1:0] V_MAX  = CORDW'(V_TOTAL - 1);
    localparam logic [CORDW-1:0] H_ACT  = CORDW'(H_RES);
    localparam logic [CORDW-1:0] V_ACT  = CORDW'(V_RES);
    localparam logic [CORDW-1:0] HS_BEG = CORDW'(H_RES + H_FP);
    localparam logic [CORDW-1:0] HS_END = CORDW'(H_RES + H_FP + H_SYNC);
    localparam logic [CORDW-1:0] VS_BEG = CORDW'(V_RES + V_FP);
    localparam logic [CORDW-1:0] VS_END = CORDW'(V_RES + V_FP + V_SYNC);
    localparam logic [SW-1:0]    SETTLE_LAST = (LOCK_WAIT > 0) ? SW'(LOCK_WAIT - 1) : {SW{1'b0}};

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic             lk_meta_r;
    logic             lk_r;
    logic [SW-1:0]    settle_cnt_r;
    logic             run_s;
    logic [CORDW-1:0] sx_s;
    logic [CORDW-1:0] sy_s;
    logic             de_s;
    logic             hs_s;
    logic             vs_s;
    logic             line_s;
    logic             frame_s;

    // Two-flop synchroniser for the asynchronous lock input
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lk_meta_r <= 1'b0;
            lk_r      <= 1'b0;
        end else begin
            lk_meta_r <= i_locked;
            lk_r      <= lk_meta_r;
        end
    end

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= WAIT_LOCK;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic; losing lock always returns to WAIT_LOCK
    always_comb begin
        state_s = WAIT_LOCK;
        case (state_r)
            WAIT_LOCK: begin
                if (lk_r) begin
                    state_s = (LOCK_WAIT == 0) ? RUN : SETTLE;
                end else begin
                    state_s = WAIT_LOCK;
                end
            end
            SETTLE: begin
                if (!lk_r) begin
                    state_s = WAIT_LOCK;
                end else if (settle_cnt_r == SETTLE_LAST) begin
                    state_s = RUN;
                end else begin
                    state_s = SETTLE;
                end
            end
            RUN: begin
                if (lk_r) begin
                    state_s = RUN;
                end else begin
                    state_s = WAIT_LOCK;
                end
            end
            default: state_s = WAIT_LOCK;
        endcase
    end

    // Settle counter: only advances while staying in SETTLE, so any exit clears it
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            settle_cnt_r <= {SW{1'b0}};
        end else if (state_r == SETTLE && state_s == SETTLE) begin
            settle_cnt_r <= settle_cnt_r + SW'(1);
        end else begin
            settle_cnt_r <= {SW{1'b0}};
        end
    end

    // Next pixel position and its decoded outputs; first RUN cycle starts at (0,0)
    always_comb begin
        run_s = (state_s == RUN);
        sx_s  = {CORDW{1'b0}};
        sy_s  = {CORDW{1'b0}};
        if (run_s && state_r == RUN) begin
            if (o_sx == H_MAX) begin
                sx_s = {CORDW{1'b0}};
                if (o_sy == V_MAX) begin
                    sy_s = {CORDW{1'b0}};
                end else begin
                    sy_s = o_sy + CORDW'(1);
                end
            end else begin
                sx_s = o_sx + CORDW'(1);
                sy_s = o_sy;
            end
        end else begin
            sx_s = {CORDW{1'b0}};
            sy_s = {CORDW{1'b0}};
        end
        de_s    = run_s && (sx_s < H_ACT) && (sy_s < V_ACT);
        hs_s    = (run_s && sx_s >= HS_BEG && sx_s < HS_END) ? H_POL : ~H_POL;
        vs_s    = (run_s && sy_s >= VS_BEG && sy_s < VS_END) ? V_POL : ~V_POL;
        line_s  = run_s && (sx_s == {CORDW{1'b0}});
        frame_s = line_s && (sy_s == {CORDW{1'b0}});
    end

    // Registered outputs describing the pixel on o_sx/o_sy
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_sx      <= {CORDW{1'b0}};
            o_sy      <= {CORDW{1'b0}};
            o_de      <= 1'b0;
            o_hs      <= ~H_POL;
            o_vs      <= ~V_POL;
            o_line    <= 1'b0;
            o_frame   <= 1'b0;
            o_running <= 1'b0;
        end else begin
            o_sx      <= sx_s;
            o_sy      <= sy_s;
            o_de      <= de_s;
            o_hs      <= hs_s;
            o_vs      <= vs_s;
            o_line    <= line_s;
            o_frame   <= frame_s;
            o_running <= run_s;
        end
    end

endmodule

// File: tb/tb_display_timings.sv
// Directed bench: a small-timing instance (no settle), a small inverted-polarity
// instance with an 8-cycle settle, and a default 720p instance for startup and line timing.
module tb_display_timings;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic lock_s, lock_p, lock_d;

    logic        s_hs, s_vs, s_de, s_frame, s_line, s_running;
    logic [15:0] s_sx, s_sy;
    logic        p_hs, p_vs, p_de, p_frame, p_line, p_running;
    logic [15:0] p_sx, p_sy;
    logic        d_hs, d_vs, d_de, d_frame, d_line, d_running;
    logic [15:0] d_sx, d_sy;

    int checks = 0;
    int errors = 0;

    display_timings #(
        .H_RES(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_RES(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b1), .LOCK_WAIT(0), .CORDW(16)
    ) dut_s (
        .i_clk(clk), .i_rst_n(rst_n), .i_locked(lock_s),
        .o_hs(s_hs), .o_vs(s_vs), .o_de(s_de), .o_frame(s_frame), .o_line(s_line),
        .o_sx(s_sx), .o_sy(s_sy), .o_running(s_running)
    );

    display_timings #(
        .H_RES(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_RES(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1'b0), .V_POL(1'b0), .LOCK_WAIT(8), .CORDW(16)
    ) dut_p (
        .i_clk(clk), .i_rst_n(rst_n), .i_locked(lock_p),
        .o_hs(p_hs), .o_vs(p_vs), .o_de(p_de), .o_frame(p_frame), .o_line(p_line),
        .o_sx(p_sx), .o_sy(p_sy), .o_running(p_running)
    );

    display_timings dut_d (
        .i_clk(clk), .i_rst_n(rst_n), .i_locked(lock_d),
        .o_hs(d_hs), .o_vs(d_vs), .o_de(d_de), .o_frame(d_frame), .o_line(d_line),
        .o_sx(d_sx), .o_sy(d_sy), .o_running(d_running)
    );

    task automatic test_reset();
        rst_n  = 1'b0;
        lock_s = 1'b1;
        lock_p = 1'b1;
        lock_d = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if ({s_running, s_de, s_frame, s_line, s_hs, s_vs} !== 6'b000000 || s_sx !== 16'd0 || s_sy !== 16'd0) begin
            errors++;
            $display("FAIL reset_s: got run/de/fr/ln/hs/vs=%b sx=%0d sy=%0d, want 000000 0 0",
                     {s_running, s_de, s_frame, s_line, s_hs, s_vs}, s_sx, s_sy);
        end
        checks++;
        if ({p_running, p_de, p_frame, p_line, p_hs, p_vs} !== 6'b000011 || p_sx !== 16'd0 || p_sy !== 16'd0) begin
            errors++;
            $display("FAIL reset_p: got run/de/fr/ln/hs/vs=%b sx=%0d sy=%0d, want 000011 0 0",
                     {p_running, p_de, p_frame, p_line, p_hs, p_vs}, p_sx, p_sy);
        end
        checks++;
        if ({d_running, d_de, d_frame, d_line, d_hs, d_vs} !== 6'b000000 || d_sx !== 16'd0 || d_sy !== 16'd0) begin
            errors++;
            $display("FAIL reset_d: got run/de/fr/ln/hs/vs=%b sx=%0d sy=%0d, want 000000 0 0",
                     {d_running, d_de, d_frame, d_line, d_hs, d_vs}, d_sx, d_sy);
        end
        // release with only the default instance locked
        rst_n  = 1'b1;
        lock_s = 1'b0;
        lock_p = 1'b0;
    endtask

    task automatic test_startup();
        int first = 0;
        for (int n = 1; n <= 1100; n++) begin
            @(negedge clk);
            if (d_running === 1'b1) begin
                first = n;
                break;
            end
        end
        checks++;
        if (first != 1027) begin
            errors++;
            $display("FAIL startup_latency: running after %0d edges, want 1027", first);
        end
        checks++;
        if (d_sx !== 16'd0 || d_sy !== 16'd0 || d_frame !== 1'b1 || d_line !== 1'b1 || d_de !== 1'b1) begin
            errors++;
            $display("FAIL startup_first: sx=%0d sy=%0d fr=%b ln=%b de=%b, want 0 0 1 1 1",
                     d_sx, d_sy, d_frame, d_line, d_de);
        end
    endtask

    task automatic test_hsync_default();
        int pos_err = 0, hs_cnt = 0, de_cnt = 0, vs_cnt = 0, hs_first = -1, hs_last = -1;
        for (int i = 0; i < 1650; i++) begin
            if (i > 0) @(negedge clk);
            if (d_sx !== 16'(i) || d_sy !== 16'd0) pos_err++;
            if (d_hs === 1'b1) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = i;
                hs_last = i;
            end
            if (d_de === 1'b1) de_cnt++;
            if (d_vs === 1'b1) vs_cnt++;
        end
        checks++;
        if (pos_err != 0) begin
            errors++;
            $display("FAIL line0_position: %0d cycles with wrong sx/sy, want 0", pos_err);
        end
        checks++;
        if (hs_first != 1390 || hs_last != 1429 || hs_cnt != 40) begin
            errors++;
            $display("FAIL line0_hsync: first=%0d last=%0d count=%0d, want 1390 1429 40",
                     hs_first, hs_last, hs_cnt);
        end
        checks++;
        if (de_cnt != 1280 || vs_cnt != 0) begin
            errors++;
            $display("FAIL line0_de_vs: de=%0d vs=%0d, want 1280 0", de_cnt, vs_cnt);
        end
        @(negedge clk);
        checks++;
        if (d_sx !== 16'd0 || d_sy !== 16'd1 || d_line !== 1'b1 || d_frame !== 1'b0 || d_de !== 1'b1) begin
            errors++;
            $display("FAIL line1_start: sx=%0d sy=%0d ln=%b fr=%b de=%b, want 0 1 1 0 1",
                     d_sx, d_sy, d_line, d_frame, d_de);
        end
        lock_d = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (d_running !== 1'b1) begin
            errors++;
            $display("FAIL d_unlock_edge2: running=%b, want 1", d_running);
        end
        @(negedge clk);
        checks++;
        if (d_running !== 1'b0 || d_de !== 1'b0 || d_sx !== 16'd0 || d_sy !== 16'd0 || d_hs !== 1'b0) begin
            errors++;
            $display("FAIL d_unlock_edge3: run=%b de=%b sx=%0d sy=%0d hs=%b, want 0 0 0 0 0",
                     d_running, d_de, d_sx, d_sy, d_hs);
        end
    endtask

    task automatic test_small_frame();
        int first = 0;
        logic [15:0] esx, esy;
        logic ede, ehs, evs, eln, efr;
        lock_s = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (s_running === 1'b1) begin
                first = n;
                break;
            end
        end
        checks++;
        if (first != 3) begin
            errors++;
            $display("FAIL small_latency: running after %0d edges, want 3", first);
        end
        for (int i = 0; i <= 96; i++) begin
            if (i > 0) @(negedge clk);
            esx = 16'(i % 8);
            esy = 16'((i / 8) % 6);
            ede = (esx < 16'd4) && (esy < 16'd3);
            ehs = (esx == 16'd5) || (esx == 16'd6);
            evs = (esy == 16'd4);
            eln = (esx == 16'd0);
            efr = eln && (esy == 16'd0);
            checks++;
            if (s_sx !== esx || s_sy !== esy || s_de !== ede || s_hs !== ehs || s_vs !== evs ||
                s_line !== eln || s_frame !== efr || s_running !== 1'b1) begin
                errors++;
                $display("FAIL small_frame[%0d]: sx=%0d sy=%0d de/hs/vs/ln/fr=%b%b%b%b%b, want %0d %0d %b%b%b%b%b",
                         i, s_sx, s_sy, s_de, s_hs, s_vs, s_line, s_frame,
                         esx, esy, ede, ehs, evs, eln, efr);
            end
        end
    endtask

    task automatic test_lock_loss();
        int first = 0;
        repeat (37) @(negedge clk);
        checks++;
        if (s_sx !== 16'd5 || s_sy !== 16'd4 || s_hs !== 1'b1 || s_vs !== 1'b1) begin
            errors++;
            $display("FAIL pre_loss: sx=%0d sy=%0d hs=%b vs=%b, want 5 4 1 1", s_sx, s_sy, s_hs, s_vs);
        end
        lock_s = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (s_running !== 1'b1) begin
            errors++;
            $display("FAIL loss_edge2: running=%b, want 1", s_running);
        end
        @(negedge clk);
        checks++;
        if ({s_running, s_de, s_frame, s_line, s_hs, s_vs} !== 6'b000000 || s_sx !== 16'd0 || s_sy !== 16'd0) begin
            errors++;
            $display("FAIL loss_edge3: run/de/fr/ln/hs/vs=%b sx=%0d sy=%0d, want 000000 0 0",
                     {s_running, s_de, s_frame, s_line, s_hs, s_vs}, s_sx, s_sy);
        end
        lock_s = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (s_running === 1'b1) begin
                first = n;
                break;
            end
        end
        checks++;
        if (first != 3 || s_sx !== 16'd0 || s_sy !== 16'd0 || s_frame !== 1'b1) begin
            errors++;
            $display("FAIL relock: after %0d edges sx=%0d sy=%0d fr=%b, want 3 0 0 1",
                     first, s_sx, s_sy, s_frame);
        end
    endtask

    task automatic test_polarity_settle();
        int first = 0;
        logic [15:0] esx, esy;
        logic ehs, evs;
        lock_p = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (p_running === 1'b1) begin
                first = n;
                break;
            end
        end
        checks++;
        if (first != 11) begin
            errors++;
            $display("FAIL settle_latency: running after %0d edges, want 11", first);
        end
        for (int i = 0; i < 48; i++) begin
            if (i > 0) @(negedge clk);
            esx = 16'(i % 8);
            esy = 16'(i / 8);
            ehs = !((esx == 16'd5) || (esx == 16'd6));
            evs = !(esy == 16'd4);
            checks++;
            if (p_sx !== esx || p_sy !== esy || p_hs !== ehs || p_vs !== evs) begin
                errors++;
                $display("FAIL neg_pol[%0d]: sx=%0d sy=%0d hs=%b vs=%b, want %0d %0d %b %b",
                         i, p_sx, p_sy, p_hs, p_vs, esx, esy, ehs, evs);
            end
        end
    endtask

    task automatic test_glitch();
        int first = 0;
        lock_p = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (p_running !== 1'b0 || p_hs !== 1'b1 || p_vs !== 1'b1 || p_de !== 1'b0) begin
            errors++;
            $display("FAIL p_unlock: run=%b hs=%b vs=%b de=%b, want 0 1 1 0", p_running, p_hs, p_vs, p_de);
        end
        lock_p = 1'b1;
        repeat (5) @(negedge clk);
        lock_p = 1'b0;
        @(negedge clk);
        lock_p = 1'b1;
        for (int n = 7; n <= 40; n++) begin
            @(negedge clk);
            if (p_running === 1'b1) begin
                first = n;
                break;
            end
        end
        checks++;
        if (first != 17) begin
            errors++;
            $display("FAIL glitch_restart: running after %0d edges, want 17", first);
        end
    endtask

    task automatic test_async_reset();
        repeat (5) @(negedge clk);
        checks++;
        if (s_running !== 1'b1 || p_running !== 1'b1) begin
            errors++;
            $display("FAIL pre_async: run_s=%b run_p=%b, want 1 1", s_running, p_running);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({s_running, s_de, s_frame, s_line, s_hs, s_vs} !== 6'b000000 || s_sx !== 16'd0 || s_sy !== 16'd0) begin
            errors++;
            $display("FAIL async_rst_s: run/de/fr/ln/hs/vs=%b sx=%0d sy=%0d, want 000000 0 0",
                     {s_running, s_de, s_frame, s_line, s_hs, s_vs}, s_sx, s_sy);
        end
        checks++;
        if ({p_running, p_de, p_frame, p_line, p_hs, p_vs} !== 6'b000011 || p_sx !== 16'd0 || p_sy !== 16'd0) begin
            errors++;
            $display("FAIL async_rst_p: run/de/fr/ln/hs/vs=%b sx=%0d sy=%0d, want 000011 0 0",
                     {p_running, p_de, p_frame, p_line, p_hs, p_vs}, p_sx, p_sy);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_startup();
        test_hsync_default();
        test_small_frame();
        test_lock_loss();
        test_polarity_settle();
        test_glitch();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
